// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns/InvMixColumns over a vector, LANES columns per cycle
module mix_columns_seq #(
  parameter int REG_SIZE = 32,
  parameter int VEC_SIZE = 4,
  parameter int LANES    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_inv,
  input  logic [VEC_SIZE*REG_SIZE-1:0] vect,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [VEC_SIZE*REG_SIZE-1:0] new_vect,
  output logic                         busy
);
  localparam int IW = VEC_SIZE > 1 ? $clog2(VEC_SIZE) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]                   state;
  logic [IW-1:0]                idx;
  logic [VEC_SIZE*REG_SIZE-1:0] cap;
  logic                         inv_q;
  logic                         last;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] c, input logic inv);
    logic [7:0] b [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] t2, t4, t8;
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      b[j]  = c[31-8*j -: 8];
      t2    = xt(b[j]);
      t4    = xt(t2);
      t8    = xt(t4);
      m2[j] = t2;
      m3[j] = t2 ^ b[j];
      m9[j] = t8 ^ b[j];
      mb[j] = t8 ^ t2 ^ b[j];
      md[j] = t8 ^ t4 ^ b[j];
      me[j] = t8 ^ t4 ^ t2;
    end
    // row i is the circulant of {2,3,1,1} / {E,B,D,9} rotated by i
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = inv ? me[2'(i)] ^ mb[2'(i+1)] ^ md[2'(i+2)] ^ m9[2'(i+3)]
                           : m2[2'(i)] ^ m3[2'(i+1)] ^ b[2'(i+2)] ^ b[2'(i+3)];
    return r;
  endfunction
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state == RUN;
  assign last      = idx == IW'(VEC_SIZE - LANES);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cap      <= '0;
      inv_q    <= 1'b0;
      new_vect <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        cap   <= vect;
        inv_q <= in_inv;
        idx   <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      for (int l = 0; l < LANES; l++)
        new_vect[(int'(idx)+l)*REG_SIZE +: REG_SIZE] <= mix(cap[(int'(idx)+l)*REG_SIZE +: REG_SIZE], inv_q);
      idx   <= last ? '0 : idx + IW'(LANES);
      state <= last ? DONE : RUN;
    end else begin
      state <= out_ready ? IDLE : DONE;
    end
  end
endmodule
